// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and channel-index width.
// Pure declarations, no logic or latency.
// No flow control of its own.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A two-channel mux still needs a one-bit index, so never return zero.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search: first requester at or above ptr, else lowest requester.
// Purely combinational, zero latency.
// No backpressure; the caller qualifies the grant.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = chan_w(NUM_IN)
)(
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [NUM_IN-1:0] hi_mask;
    logic [NUM_IN-1:0] hi_req;

    always_comb begin
        hi_mask   = '0;
        gnt_idx   = '0;
        gnt_valid = |req;
        for (int i = 0; i < NUM_IN; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        hi_req = req & hi_mask;
        // Downward scan so the lowest matching index is the one left standing.
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (|hi_req) begin
                if (hi_req[i]) gnt_idx = SEL_W'(i);
            end else begin
                if (req[i]) gnt_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream mux, fixed select or round-robin; optional out_parity via STREAM_MUX_PARITY_EN.
// Latency 1 cycle (registered output), 1 beat/cycle with out_ready high.
// Backpressure: output register stalls while out_valid && !out_ready, holding all in_ready low.
module stream_mux
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int WIDTH  = 8,
    localparam int SEL_W  = chan_w(NUM_IN)
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
`ifdef STREAM_MUX_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_vld_q, out_vld_d;
    logic             sel_err_q, sel_err_d;
    logic             par_q, par_d;

    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;
    logic             fixed_ok, load, grant_vld, take, xfer, sel_vld;
    logic [SEL_W-1:0] g;
    logic [WIDTH-1:0] sel_dat;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_vld),
        .gnt_idx   (arb_idx)
    );

    always_comb begin
        fixed_ok = (int'(sel) < NUM_IN);
        load     = !out_vld_q || out_ready;
        if (mode == MODE_RR) begin
            grant_vld = arb_vld;
            g         = arb_idx;
        end else begin
            grant_vld = fixed_ok;
            g         = sel;
        end

        // Explicit decode keeps an out-of-range sel from ever slicing past in_data.
        sel_dat = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (g == SEL_W'(i)) begin
                sel_dat = in_data[i*WIDTH +: WIDTH];
                sel_vld = in_valid[i];
            end
        end

        take = reset_n && load && grant_vld;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = take && (g == SEL_W'(i));
        end
        xfer = take && sel_vld;

        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        par_d      = par_q;
        out_vld_d  = out_vld_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) out_vld_d = xfer;
        if (xfer) begin
            out_data_d = sel_dat;
            out_chan_d = g;
            par_d      = ^sel_dat;
            if (mode == MODE_RR) begin
                rr_ptr_d = (g == SEL_W'(NUM_IN - 1)) ? '0 : g + SEL_W'(1);
            end
        end
        sel_err_d = (mode == MODE_FIXED) && !fixed_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_chan_q <= '0;
            out_vld_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            out_vld_q  <= out_vld_d;
            sel_err_q  <= sel_err_d;
            par_q      <= par_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_vld_q;
    assign sel_err   = sel_err_q;
`ifdef STREAM_MUX_PARITY_EN
    assign out_parity = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance driven from a vector table and a
// 3-channel instance for the out-of-range select case; parity checked when STREAM_MUX_PARITY_EN is set.
module tb_stream_mux;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        mode4, ordy4, ov4, err4;
    logic [1:0]  sel4, oc4;
    logic [31:0] data4;
    logic [3:0]  vld4, rdy4;
    logic [7:0]  od4;
    logic        par4;

    // 3-channel instance
    logic        mode3, ordy3, ov3, err3;
    logic [1:0]  sel3, oc3;
    logic [23:0] data3;
    logic [2:0]  vld3, rdy3;
    logic [7:0]  od3;
    logic        par3;

    stream_mux #(.NUM_IN(4), .WIDTH(8)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode4),
        .sel       (sel4),
        .in_data   (data4),
        .in_valid  (vld4),
        .in_ready  (rdy4),
        .out_data  (od4),
        .out_chan  (oc4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .sel_err   (err4)
`ifdef STREAM_MUX_PARITY_EN
        ,
        .out_parity(par4)
`endif
    );

    stream_mux #(.NUM_IN(3), .WIDTH(8)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (data3),
        .in_valid  (vld3),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_chan  (oc3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .sel_err   (err3)
`ifdef STREAM_MUX_PARITY_EN
        ,
        .out_parity(par3)
`endif
    );

`ifndef STREAM_MUX_PARITY_EN
    assign par4 = 1'b0;
    assign par3 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;   // expected in_ready this cycle
        logic       ov;    // expected registered outputs after the edge
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        //         mode  sel    vld     ordy  rdy      ov    od     oc
        tbl[0]  = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // round robin 0,1,2,3,0
        tbl[1]  = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // skip idle channels
        tbl[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[8]  = '{1'b1, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 8'h22, 2'd1}; // stall three cycles
        tbl[9]  = '{1'b1, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[10] = '{1'b1, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[11] = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b0100, 1'b1, 8'h33, 2'd2}; // drain and load, no bubble
        tbl[12] = '{1'b0, 2'd2, 4'hF,   1'b1, 4'b0100, 1'b1, 8'h33, 2'd2}; // fixed sel=2
        tbl[13] = '{1'b0, 2'd2, 4'hF,   1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[14] = '{1'b0, 2'd2, 4'h0,   1'b1, 4'b0100, 1'b0, 8'h33, 2'd2}; // ready without valid
        tbl[15] = '{1'b1, 2'd0, 4'h0,   1'b0, 4'b0000, 1'b0, 8'h33, 2'd2}; // empty reg loads nothing
        tbl[16] = '{1'b1, 2'd0, 4'hF,   1'b1, 4'b1000, 1'b1, 8'h44, 2'd3}; // ptr untouched by fixed beats
        tbl[17] = '{1'b0, 2'd0, 4'hF,   1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[18] = '{1'b0, 2'd0, 4'hF,   1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};

        data4 = {8'h44, 8'h33, 8'h22, 8'h11};
        data3 = {8'hCC, 8'hBB, 8'hAA};
        reset_n = 1'b0;
        mode4 = 1'b1; sel4 = 2'd0; vld4 = 4'hF; ordy4 = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; vld3 = 3'b111; ordy3 = 1'b1;

        // Reset with every channel requesting
        tick();
        tick();
        chk("rst in_ready4", 32'(rdy4), 32'h0);
        chk("rst in_ready3", 32'(rdy3), 32'h0);
        chk("rst out_valid", 32'(ov4), 32'h0);
        chk("rst out_data", 32'(od4), 32'h0);
        chk("rst out_chan", 32'(oc4), 32'h0);
        chk("rst sel_err", 32'(err4), 32'h0);
        chk("rst parity", 32'(par4), 32'h0);

        reset_n = 1'b1;
        vld3 = 3'b000;
        for (int k = 0; k < NV; k++) begin
            mode4 = tbl[k].mode;
            sel4  = tbl[k].sel;
            vld4  = tbl[k].vld;
            ordy4 = tbl[k].ordy;
            #1;
            chk($sformatf("v%0d in_ready", k), 32'(rdy4), 32'(tbl[k].rdy));
            tick();
            chk($sformatf("v%0d out_valid", k), 32'(ov4), 32'(tbl[k].ov));
            chk($sformatf("v%0d out_data", k), 32'(od4), 32'(tbl[k].od));
            chk($sformatf("v%0d out_chan", k), 32'(oc4), 32'(tbl[k].oc));
            chk($sformatf("v%0d sel_err", k), 32'(err4), 32'h0);
        end

        // Three-channel instance: out-of-range select
        vld3 = 3'b111; sel3 = 2'd1;
        #1;
        chk("n3 sel1 in_ready", 32'(rdy3), 32'b010);
        tick();
        chk("n3 sel1 out_valid", 32'(ov3), 32'h1);
        chk("n3 sel1 out_data", 32'(od3), 32'hBB);
        chk("n3 sel1 sel_err", 32'(err3), 32'h0);
        sel3 = 2'd3;
        #1;
        chk("n3 sel3 in_ready", 32'(rdy3), 32'b000);
        tick();
        chk("n3 sel3 out_valid", 32'(ov3), 32'h0);
        chk("n3 sel3 out_chan", 32'(oc3), 32'h1);
        chk("n3 sel3 sel_err", 32'(err3), 32'h1);
        sel3 = 2'd0;
        #1;
        chk("n3 sel0 in_ready", 32'(rdy3), 32'b001);
        tick();
        chk("n3 sel0 sel_err", 32'(err3), 32'h0);
        chk("n3 sel0 out_data", 32'(od3), 32'hAA);
        chk("n3 sel0 out_chan", 32'(oc3), 32'h0);

`ifdef STREAM_MUX_PARITY_EN
        mode4 = 1'b0; sel4 = 2'd0; vld4 = 4'b0001; ordy4 = 1'b1;
        data4[7:0] = 8'h07;
        tick();
        chk("par 07 data", 32'(od4), 32'h07);
        chk("par 07", 32'(par4), 32'h1);
        data4[7:0] = 8'h03;
        tick();
        chk("par 03 data", 32'(od4), 32'h03);
        chk("par 03", 32'(par4), 32'h0);
        data4[7:0] = 8'h11;
`endif

        // Reset while a beat is stalled in the output register
        mode4 = 1'b1; vld4 = 4'hF; ordy4 = 1'b0;
        tick();
        chk("pre mid-reset out_valid", 32'(ov4), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid-reset in_ready", 32'(rdy4), 32'h0);
        tick();
        chk("mid-reset out_valid", 32'(ov4), 32'h0);
        chk("mid-reset out_data", 32'(od4), 32'h0);
        reset_n = 1'b1; ordy4 = 1'b1;
        #1;
        chk("post-reset ptr0 in_ready", 32'(rdy4), 32'b0001);
        tick();
        chk("post-reset out_chan", 32'(oc4), 32'h0);
        chk("post-reset out_valid", 32'(ov4), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised successor to the team's 4:1 bit multiplexers.
- Selects one of NUM_IN channels, each WIDTH bits wide with valid/ready handshake, onto a single registered output stream.
- Selection is either a fixed select port or fair round-robin arbitration among the valid channels.
- Sits between producer channels and a shared downstream consumer (bus or ALU operand path).

Parameters:
- NUM_IN, 4, number of input channels (2..16, need not be a power of 2).
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(NUM_IN), select/channel-index width (derived, not overridden).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  index of the channel that out_data came from.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts beat.
- sel_err  output  1  registered one-cycle pulse: fixed mode with sel >= NUM_IN.

Behaviour:
- Reset: sampled on clk edge while reset_n=0. Clears out_valid=0, out_data=0, out_chan=0, sel_err=0 and rr_ptr=0. in_ready is forced to all-0 while reset_n=0.
- Reset mid-transfer: any buffered beat is discarded.
- load = !out_valid || out_ready. The output register accepts a new beat when empty or when draining in the same cycle.
- Grant g:
  - Fixed mode: g = sel if sel < NUM_IN, otherwise no grant.
  - Round-robin mode: g = first i with in_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_IN. No grant if no valid.
- in_ready[i] = reset_n && load && granted && (g == i). It is combinational from in_valid/sel/mode/out_ready.
- Fixed mode: in_ready[sel] may be high while in_valid[sel]=0.
- Transfer on channel g when in_valid[g] && in_ready[g]. The next edge loads out_data = channel g data, out_chan = g, out_valid = 1.
- Latency is 1 cycle. Throughput is 1 beat/cycle with out_ready held high.
- When load=1 and no transfer occurs, the next edge sets out_valid=0. out_data and out_chan hold their last values.
- While out_valid && !out_ready: out_data and out_chan remain stable and all in_ready stay 0.
- rr_ptr:
  - Updated only on a round-robin transfer: rr_ptr <= (g == NUM_IN-1) ? 0 : g+1.
  - Fixed-mode transfers leave rr_ptr unchanged.
- Mode or sel changes take effect the same cycle for arbitration. A beat already in the output register is unaffected.
- sel_err pulses for one cycle after any cycle in which mode=0, sel >= NUM_IN and reset_n=1. Only reachable when NUM_IN is not a power of 2.
- Simultaneous out_ready=1 and a new transfer: the old beat is consumed and the new beat loaded on the same edge; no bubble.

Optional Feature:
- Macro: STREAM_MUX_PARITY_EN.
- Defined: adds output port out_parity (1 bit), registered alongside out_data as the XOR-reduce of the loaded data (even parity). Reset value 0. Held with out_data.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, and the channel-index width helper function.
- One sub-module, rr_arbiter: inputs req[NUM_IN], ptr[SEL_W]; outputs gnt_valid and gnt_idx. Purely combinational wrap-around priority search.
- Pointer state and the output register live in stream_mux.

Test Plan:
- Reset: hold reset_n=0 with all in_valid=1 for 2 cycles -> out_valid=0, out_data=0, out_chan=0, in_ready=0. First transfer occurs the cycle after release.
- Fixed mode, NUM_IN=4, WIDTH=8: sel=2, channel data 0x11/0x22/0x33/0x44, all valid, out_ready=1 -> out_data=0x33, out_chan=2 every cycle; only in_ready[2]=1.
- Round-robin fairness: all four valid, out_ready=1 -> out_chan sequence 0,1,2,3,0.
- Skipping: only channels 1 and 3 valid -> out_chan sequence 1,3,1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x22 -> data stable, in_ready=0. Set out_ready=1 -> the next beat loads on the same edge, with no bubble.
- NUM_IN=3, fixed mode, sel=3 -> in_ready=0, out_valid drops to 0, and sel_err pulses 1 for one cycle.
- With STREAM_MUX_PARITY_EN: out_data=0x07 -> out_parity=1; out_data=0x03 -> out_parity=0.
